eco_medidor: RTL and testbench
==============================

Name: eco_medidor

Overview:
- Receive-side counterpart of the ultrasonic trigger pulse generator.
- Once a trigger has been issued, arms itself and times the sensor's echo pulse width, converting it to whole centimetres with a prescaler.
- Reports one result per trigger with a single-cycle valid strobe, or a timeout flag if no echo arrives.
- Sits between the trigger generator and the distance display/logic in the ultrasonic path.

Parameters:
- TICKS_PER_CM, 2900, CLKOUT1 cycles per centimetre of round-trip echo (58 us/cm at 50 MHz); must be >= 2.
- MAX_CM, 400, saturation value of the distance result.
- DIST_W, 9, width of the distance output; must hold MAX_CM.
- WAIT_TIMEOUT, 1500000, cycles allowed in WAIT_RISE before declaring timeout.

Ports:
- CLKOUT1  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-low reset: 0 = reset, sampled on the CLKOUT1 rising edge.
- start  input  1  trigger-issued strobe from the pulse generator; level, sampled each cycle.
- echo  input  1  raw sensor echo, asynchronous to CLKOUT1.
- distance  output  DIST_W  last measured distance in cm; held until the next result.
- valid  output  1  one-cycle strobe: distance updated.
- timeout  output  1  one-cycle strobe: no echo rising edge within WAIT_TIMEOUT.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (reset=0 at a clock edge): state=IDLE, distance=0, valid=0, timeout=0, busy=0, prescaler=0, cm counter=0, wait counter=0, synchroniser flops=0.
- Echo path: 2-flop synchroniser, then a third flop for edge detection.
  - rise = s2 & ~s3; fall = ~s2 & s3.
  - Edge detect lags the raw echo by 2 cycles; this lag is identical at both edges, so width is unaffected.
- IDLE, busy=0:
  - start=1 -> WAIT_RISE; clear wait counter, prescaler and cm counter.
- WAIT_RISE:
  - rise -> MEASURE.
  - Otherwise increment the wait counter; when it reaches WAIT_TIMEOUT-1 -> IDLE, with timeout=1 for exactly one cycle. distance is not changed.
  - start held or re-asserted here is ignored.
- MEASURE, each cycle while the echo is high:
  - Prescaler increments. At TICKS_PER_CM-1 the prescaler wraps to 0 and the cm counter increments, saturating at MAX_CM (no wrap).
  - fall -> DONE.
- DONE, one cycle:
  - distance <= cm counter (floor of width/TICKS_PER_CM, capped at MAX_CM); valid=1 for this cycle only.
  - Then -> IDLE.
- Latency: valid asserts 4 cycles after the echo falling edge at the pin (2 sync, 1 edge, 1 DONE).
- Rising edge already present on entry: if echo is high on the start cycle, the rise is missed. Wait for the next rise or time out; never measure a partial pulse.
- Simultaneous rise and timeout in the same cycle: rise wins.
- start in MEASURE or DONE: ignored. A new trigger is accepted only in IDLE, so there is at most one result per start.
- Echo stuck high: the cm counter saturates at MAX_CM and stays in MEASURE until the fall. There is no second timeout; a reset recovers.
- Mid-operation reset: immediate return to the reset values above. No valid or timeout strobe is generated by a reset.
- valid and timeout are never high in the same cycle.

Optional Feature:
- Macro: ECO_FILTRO_EN.
- Defined:
  - A glitch filter sits after the synchroniser. The filtered echo changes only after s2 has held a new value for 4 consecutive cycles.
  - Pulses shorter than 4 cycles (high or low) are ignored.
  - Edge latency grows by 4 cycles at both edges, so the measured width is unchanged; valid appears 8 cycles after the pin falling edge.
- Not defined: no filter; the edge detector is fed directly from s2, with the behaviour and latency given above.

Test Plan (TICKS_PER_CM=4, MAX_CM=10, DIST_W=4, WAIT_TIMEOUT=50, filter off unless stated):
- Reset: hold reset=0 for 3 cycles with echo toggling -> distance=0, valid=0, timeout=0, busy=0. Release -> state IDLE.
- Normal measurement: start pulse, then echo high for 22 cycles -> one valid pulse, distance=5, 4 cycles after the echo fall; busy then drops.
- Saturation: start, then echo high for 80 cycles -> distance=10; valid once.
- Timeout: start with no echo -> timeout=1 for one cycle, 50 cycles after entering WAIT_RISE; distance retains its previous value; valid never asserts.
- Reset mid-measure: start, echo high for 10 cycles, reset=0 for 1 cycle, echo low -> no valid, distance=0, busy=0. A following start plus an 8-cycle echo -> distance=2.
- ECO_FILTRO_EN defined: start, a 2-cycle echo glitch, then a 16-cycle echo -> single valid, distance=4, glitch ignored. Without the macro, the same stimulus gives distance=0 from the glitch.

Source files
------------

// File: rtl/eco_medidor.sv
// eco_medidor: times the ultrasonic echo pulse after a trigger and reports its width in whole cm.
// Latency: valid 4 cycles after the echo pin falls (8 with ECO_FILTRO_EN); timeout WAIT_TIMEOUT cycles after arming.
// Optional glitch filter on the synchronised echo: define ECO_FILTRO_EN. Accepts start only in IDLE.
module eco_medidor #(
  parameter int TICKS_PER_CM = 2900,
  parameter int MAX_CM       = 400,
  parameter int DIST_W       = 9,
  parameter int WAIT_TIMEOUT = 1500000
) (
  input  logic              CLKOUT1,
  input  logic              reset,
  input  logic              start,
  input  logic              echo,
  output logic [DIST_W-1:0] distance,
  output logic              valid,
  output logic              timeout,
  output logic              busy
);

  localparam int PRE_W  = (TICKS_PER_CM > 2) ? $clog2(TICKS_PER_CM) : 1;
  localparam int WAIT_W = (WAIT_TIMEOUT > 2) ? $clog2(WAIT_TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RISE = 2'd1,
    MEASURE   = 2'd2,
    DONE      = 2'd3
  } state_t;

  state_t              state_q;
  logic [PRE_W-1:0]    pre_q, pre_d;
  logic [DIST_W-1:0]   cm_q, cm_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [DIST_W-1:0]   dist_q;
  logic                valid_q, timeout_q, busy_q;

  logic sync1_q, sync2_q, edge_q;
  logic echo_f;
  logic rise, fall;

  // Two-flop synchroniser for the asynchronous echo pin
  always_ff @(posedge CLKOUT1) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= echo;
      sync2_q <= sync1_q;
    end
  end

`ifdef ECO_FILTRO_EN
  logic       filt_q;
  logic [1:0] filt_cnt_q;

  // Filtered echo follows sync2 only after it has held a new level for 4 cycles
  always_ff @(posedge CLKOUT1) begin
    if (!reset) begin
      filt_q     <= 1'b0;
      filt_cnt_q <= 2'd0;
    end else if (sync2_q != filt_q) begin
      if (filt_cnt_q == 2'd3) begin
        filt_q     <= sync2_q;
        filt_cnt_q <= 2'd0;
      end else begin
        filt_cnt_q <= filt_cnt_q + 2'd1;
      end
    end else begin
      filt_cnt_q <= 2'd0;
    end
  end

  assign echo_f = filt_q;
`else
  assign echo_f = sync2_q;
`endif

  // Delayed copy of the (filtered) echo for edge detection
  always_ff @(posedge CLKOUT1) begin
    if (!reset) begin
      edge_q <= 1'b0;
    end else begin
      edge_q <= echo_f;
    end
  end

  assign rise = echo_f & ~edge_q;
  assign fall = ~echo_f & edge_q;

  // One echo-high cycle worth of counting: prescaler wraps into a saturating cm count
  always_comb begin
    pre_d  = pre_q + PRE_W'(1);
    cm_d   = cm_q;
    wait_d = wait_q + WAIT_W'(1);
    if (pre_q == PRE_W'(TICKS_PER_CM - 1)) begin
      pre_d = '0;
      if (cm_q < DIST_W'(MAX_CM)) begin
        cm_d = cm_q + DIST_W'(1);
      end
    end
  end

  // Measurement FSM with registered strobes, busy and result
  always_ff @(posedge CLKOUT1) begin
    if (!reset) begin
      state_q   <= IDLE;
      pre_q     <= '0;
      cm_q      <= '0;
      wait_q    <= '0;
      dist_q    <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= WAIT_RISE;
            busy_q  <= 1'b1;
            wait_q  <= '0;
            pre_q   <= '0;
            cm_q    <= '0;
          end
        end
        WAIT_RISE: begin
          // The rise cycle is the first high cycle of the pulse, so it is counted here
          if (rise) begin
            state_q <= MEASURE;
            pre_q   <= pre_d;
            cm_q    <= cm_d;
          end else if (wait_q == WAIT_W'(WAIT_TIMEOUT - 1)) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            timeout_q <= 1'b1;
          end else begin
            wait_q <= wait_d;
          end
        end
        MEASURE: begin
          if (fall) begin
            state_q <= DONE;
          end else if (echo_f) begin
            pre_q <= pre_d;
            cm_q  <= cm_d;
          end
        end
        DONE: begin
          dist_q  <= cm_q;
          valid_q <= 1'b1;
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign distance = dist_q;
  assign valid    = valid_q;
  assign timeout  = timeout_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_eco_medidor.sv
// Testbench for eco_medidor: directed scenarios plus randomized pulse widths
// checked against an arithmetic model (floor(width / TICKS_PER_CM), capped at MAX_CM).
`timescale 1ns/1ps
module tb_eco_medidor;

  localparam int TPC  = 4;
  localparam int MAXC = 10;
  localparam int DW   = 4;
  localparam int WT   = 50;
`ifdef ECO_FILTRO_EN
  localparam int LAT  = 8;
  localparam int FILT = 1;
`else
  localparam int LAT  = 4;
  localparam int FILT = 0;
`endif

  logic          clk   = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          echo  = 1'b0;
  logic [DW-1:0] distance;
  logic          valid, timeout, busy;

  int n_checks = 0;
  int n_fail   = 0;
  int valid_cnt = 0, timeout_cnt = 0, overlap_cnt = 0;

  eco_medidor #(
    .TICKS_PER_CM(TPC),
    .MAX_CM(MAXC),
    .DIST_W(DW),
    .WAIT_TIMEOUT(WT)
  ) dut (
    .CLKOUT1 (clk),
    .reset   (reset),
    .start   (start),
    .echo    (echo),
    .distance(distance),
    .valid   (valid),
    .timeout (timeout),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // Strobe bookkeeping, sampled mid-cycle
  always @(negedge clk) begin
    if (valid) valid_cnt++;
    if (timeout) timeout_cnt++;
    if (valid && timeout) overlap_cnt++;
  end

  function automatic int model_cm(input int w);
    int c;
    c = w / TPC;
    return (c > MAXC) ? MAXC : c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Drive one echo pulse, then watch a bounded window for the result strobe
  task automatic run_pulse(input int w, output int lat, output int nv);
    int v0;
    v0  = valid_cnt;
    lat = -1;
    echo = 1'b1;
    repeat (w) tick();
    echo = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (valid && lat < 0) lat = k;
    end
    nv = valid_cnt - v0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      echo = ~echo;
      tick();
    end
    echo = 1'b0;
    n_checks++; if (distance !== DW'(0)) begin n_fail++; $display("FAIL reset_distance: got %0d expected 0", distance); end
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid); end
    n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b expected 0", timeout); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    reset = 1'b1;
    repeat (4) tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_release_busy: got %b expected 0", busy); end
  endtask

  task automatic test_normal();
    int lat, nv;
    issue_start();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL normal_busy_armed: got %b expected 1", busy); end
    run_pulse(22, lat, nv);
    n_checks++; if (nv != 1) begin n_fail++; $display("FAIL normal_valid_count: got %0d expected 1", nv); end
    n_checks++; if (lat != LAT) begin n_fail++; $display("FAIL normal_latency: got %0d expected %0d", lat, LAT); end
    n_checks++; if (distance !== DW'(5)) begin n_fail++; $display("FAIL normal_distance: got %0d expected 5", distance); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL normal_busy_after: got %b expected 0", busy); end
  endtask

  task automatic test_saturation();
    int lat, nv;
    issue_start();
    run_pulse(80, lat, nv);
    n_checks++; if (nv != 1) begin n_fail++; $display("FAIL sat_valid_count: got %0d expected 1", nv); end
    n_checks++; if (distance !== DW'(MAXC)) begin n_fail++; $display("FAIL sat_distance: got %0d expected %0d", distance, MAXC); end
  endtask

  task automatic test_timeout();
    int lat, v0, t0;
    logic [DW-1:0] d0;
    d0 = distance;
    v0 = valid_cnt;
    t0 = timeout_cnt;
    lat = -1;
    issue_start();
    for (int k = 1; k <= 80; k++) begin
      tick();
      if (timeout && lat < 0) lat = k;
    end
    n_checks++; if (lat != WT) begin n_fail++; $display("FAIL timeout_latency: got %0d expected %0d", lat, WT); end
    n_checks++; if (timeout_cnt - t0 != 1) begin n_fail++; $display("FAIL timeout_width: got %0d cycles expected 1", timeout_cnt - t0); end
    n_checks++; if (valid_cnt != v0) begin n_fail++; $display("FAIL timeout_no_valid: got %0d strobes expected 0", valid_cnt - v0); end
    n_checks++; if (distance !== d0) begin n_fail++; $display("FAIL timeout_distance_held: got %0d expected %0d", distance, d0); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL timeout_busy: got %b expected 0", busy); end
  endtask

  task automatic test_reset_mid();
    int lat, nv, v0;
    issue_start();
    echo = 1'b1;
    repeat (10) tick();
    reset = 1'b0;
    tick();
    echo  = 1'b0;
    reset = 1'b1;
    v0 = valid_cnt;
    repeat (15) tick();
    n_checks++; if (valid_cnt != v0) begin n_fail++; $display("FAIL rstmid_no_valid: got %0d strobes expected 0", valid_cnt - v0); end
    n_checks++; if (distance !== DW'(0)) begin n_fail++; $display("FAIL rstmid_distance: got %0d expected 0", distance); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    issue_start();
    run_pulse(8, lat, nv);
    n_checks++; if (nv != 1) begin n_fail++; $display("FAIL rstmid_after_valid_count: got %0d expected 1", nv); end
    n_checks++; if (distance !== DW'(2)) begin n_fail++; $display("FAIL rstmid_after_distance: got %0d expected 2", distance); end
  endtask

  task automatic test_late_rise();
    int lat, nv, v0;
    v0 = valid_cnt;
    echo = 1'b1;
    repeat (6) tick();
    issue_start();
    repeat (3) tick();
    echo = 1'b0;
    repeat (8) tick();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL late_rise_still_waiting: got busy %b expected 1", busy); end
    n_checks++; if (valid_cnt != v0) begin n_fail++; $display("FAIL late_rise_partial: got %0d strobes expected 0", valid_cnt - v0); end
    run_pulse(12, lat, nv);
    n_checks++; if (nv != 1) begin n_fail++; $display("FAIL late_rise_valid_count: got %0d expected 1", nv); end
    n_checks++; if (distance !== DW'(3)) begin n_fail++; $display("FAIL late_rise_distance: got %0d expected 3", distance); end
  endtask

  task automatic test_back_to_back();
    int lat, nv, t0;
    t0 = timeout_cnt;
    start = 1'b1;
    tick();
    run_pulse(9, lat, nv);
    n_checks++; if (nv != 1) begin n_fail++; $display("FAIL b2b_first_valid_count: got %0d expected 1", nv); end
    n_checks++; if (lat != LAT) begin n_fail++; $display("FAIL b2b_first_latency: got %0d expected %0d", lat, LAT); end
    n_checks++; if (distance !== DW'(2)) begin n_fail++; $display("FAIL b2b_first_distance: got %0d expected 2", distance); end
    run_pulse(17, lat, nv);
    start = 1'b0;
    n_checks++; if (nv != 1) begin n_fail++; $display("FAIL b2b_second_valid_count: got %0d expected 1", nv); end
    n_checks++; if (distance !== DW'(4)) begin n_fail++; $display("FAIL b2b_second_distance: got %0d expected 4", distance); end
    repeat (70) tick();
    n_checks++; if (timeout_cnt - t0 != 1) begin n_fail++; $display("FAIL b2b_rearm_timeout: got %0d expected 1", timeout_cnt - t0); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_end: got %b expected 0", busy); end
  endtask

  task automatic test_filter();
    int v0, exp_d;
    exp_d = (FILT != 0) ? 4 : 0;
    v0 = valid_cnt;
    issue_start();
    echo = 1'b1;
    repeat (2) tick();
    echo = 1'b0;
    repeat (6) tick();
    echo = 1'b1;
    repeat (16) tick();
    echo = 1'b0;
    repeat (40) tick();
    n_checks++; if (valid_cnt - v0 != 1) begin n_fail++; $display("FAIL filter_valid_count: got %0d expected 1", valid_cnt - v0); end
    n_checks++; if (distance !== DW'(exp_d)) begin n_fail++; $display("FAIL filter_distance: got %0d expected %0d", distance, exp_d); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL filter_busy: got %b expected 0", busy); end
  endtask

  task automatic test_random();
    int w, gap, lat, nv, exp_d;
    for (int i = 0; i < 20; i++) begin
      w     = $urandom_range(4, 60);
      gap   = $urandom_range(0, 5);
      exp_d = model_cm(w);
      issue_start();
      repeat (gap) tick();
      run_pulse(w, lat, nv);
      n_checks++; if (nv != 1) begin n_fail++; $display("FAIL rand_valid_count w=%0d: got %0d expected 1", w, nv); end
      n_checks++; if (lat != LAT) begin n_fail++; $display("FAIL rand_latency w=%0d: got %0d expected %0d", w, lat, LAT); end
      n_checks++; if (distance !== DW'(exp_d)) begin n_fail++; $display("FAIL rand_distance w=%0d: got %0d expected %0d", w, distance, exp_d); end
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_saturation();
    test_timeout();
    test_reset_mid();
    test_late_rise();
    test_back_to_back();
    test_filter();
    test_random();
    n_checks++; if (overlap_cnt != 0) begin n_fail++; $display("FAIL valid_timeout_overlap: got %0d cycles expected 0", overlap_cnt); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
